// File: rtl/qram_burst_ctrl.sv
// qram_burst_ctrl: multi-channel QRAM burst store with a complementary DDR clock pair.
// Define QRAM_PARITY_EN to store and check an even-parity bit per word.
module qram_burst_ctrl #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int BURST_LEN = 4,
    parameter int CHANNELS  = 2,
    parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWrite,
    input  logic [CH_W-1:0]   ReqChan,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic              WrValid,
    output logic              WrReady,
    input  logic [DATA_W-1:0] WrData,
    input  logic              ParityFlip,
    output logic              RdValid,
    output logic [DATA_W-1:0] RdData,
    output logic              RdLast,
    output logic              RdParityErr,
    output logic              DDRClockP,
    output logic              DDRClockN
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'(BURST_LEN - 1);
    typedef enum logic [2:0] {IDLE, ACT, WRITE, READ, PRE} state_t;
    state_t state, state_nxt;
    logic [CH_W-1:0] chan;
    logic [ADDR_W-1:0] base, addr;
    logic wr_dir, accept, beat_wr, last, chan_ok, busy, busy_nxt;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] mem [CHANNELS][DEPTH];
    assign ReqReady = (state == IDLE) && !Reset;
    assign WrReady  = state == WRITE;
    assign accept   = ReqValid && ReqReady;
    assign beat_wr  = WrReady && WrValid;
    assign last     = cnt == CNT_W'(BURST_LEN - 1);
    assign chan_ok  = 32'(chan) < CHANNELS;
    // beat address wraps within the aligned BURST_LEN block
    assign addr     = (base & ~LO_MASK) | ((base + ADDR_W'(cnt)) & LO_MASK);
    assign busy     = (state == WRITE) || (state == READ);
    assign busy_nxt = (state_nxt == WRITE) || (state_nxt == READ);
    assign DDRClockN = ~DDRClockP;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? ACT : IDLE;
            ACT:     state_nxt = wr_dir ? WRITE : READ;
            WRITE:   state_nxt = (beat_wr && last) ? PRE : WRITE;
            READ:    state_nxt = last ? PRE : READ;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            chan      <= '0;
            base      <= '0;
            wr_dir    <= 1'b0;
            cnt       <= '0;
            RdValid   <= 1'b0;
            RdLast    <= 1'b0;
            RdData    <= '0;
            DDRClockP <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                chan   <= ReqChan;
                base   <= ReqAddr;
                wr_dir <= ReqWrite;
            end
            if (state == ACT)
                cnt <= '0;
            else if (beat_wr || state == READ)
                cnt <= cnt + 1'b1;
            RdValid   <= state == READ;
            RdLast    <= (state == READ) && last;
            RdData    <= (state == READ && chan_ok) ? mem[chan][addr] : '0;
            DDRClockP <= (busy && busy_nxt) ? ~DDRClockP : 1'b0;
        end
    end
    // array is never reset; state is IDLE during reset so no beat can be written
    always_ff @(posedge Clock)
        if (beat_wr && chan_ok)
            mem[chan][addr] <= WrData;
`ifdef QRAM_PARITY_EN
    logic par_mem [CHANNELS][DEPTH];
    always_ff @(posedge Clock)
        if (beat_wr && chan_ok)
            par_mem[chan][addr] <= ^WrData ^ ParityFlip;
    always_ff @(posedge Clock or posedge Reset)
        if (Reset)
            RdParityErr <= 1'b0;
        else
            RdParityErr <= (state == READ) && chan_ok && ((^mem[chan][addr]) != par_mem[chan][addr]);
`else
    logic unused_flip;
    assign unused_flip = ParityFlip;
    assign RdParityErr = 1'b0;
`endif
endmodule
